// File: rtl/fifo_wr_burst_arbiter_if.sv
// Requester-side bus of the FIFO write-burst arbiter: per-requester burst request,
// length, data handshake and the one-hot grant.
interface fifo_wr_burst_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LW         = 7
);
    logic [N_REQ-1:0]                 req_i;
    logic [N_REQ-1:0][LW-1:0]         len_i;
    logic [N_REQ-1:0]                 valid_i;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] d_i;
    logic [N_REQ-1:0]                 ready_o;
    logic [N_REQ-1:0]                 grant_o;

    modport master (
        output req_i, len_i, valid_i, d_i,
        input  ready_o, grant_o
    );

    modport slave (
        input  req_i, len_i, valid_i, d_i,
        output ready_o, grant_o
    );
endinterface

// File: rtl/fifo_wr_burst_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ burst requesters;
// a burst is granted whole and only starts once the FIFO has room for all of it.
module fifo_wr_burst_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 2048,
    parameter int MAX_BURST  = 64,
    parameter int MARGIN     = 2,
    parameter int LW         = $clog2(MAX_BURST) + 1,
    parameter int CW         = $clog2(SIZE)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fifo_wr_burst_arbiter_if.slave req_bus,
    output logic [DATA_WIDTH-1:0]  fifo_d_o,
    output logic                   fifo_we_o,
    input  logic                   fifo_full_i,
    input  logic [CW-1:0]          fifo_count_i,
    output logic                   busy_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int IW = PW + 1;
    localparam int FW = CW + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            winner_q, rr_q, pick;
    logic [IW-1:0]            idx;
    logic                     found;
    logic [LW-1:0]            remaining_q;
    logic [N_REQ-1:0][LW-1:0] len_clamped;
    logic signed [FW-1:0]     free_words;
    logic                     room_pick, room_q, accept, last_word;
    logic [N_REQ-1:0]         ready, grant;

    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign len_clamped[g] = (req_bus.len_i[g] == '0)               ? LW'(1) :
                                (req_bus.len_i[g] > LW'(MAX_BURST))    ? LW'(MAX_BURST) :
                                                                         req_bus.len_i[g];
    end

    // Signed and wide enough that a count near SIZE goes negative instead of wrapping.
    assign free_words = $signed(FW'(SIZE)) - $signed(FW'(fifo_count_i)) - $signed(FW'(MARGIN));
    assign room_pick  = free_words >= $signed(FW'(len_clamped[pick]));
    assign room_q     = free_words >= $signed(FW'(remaining_q));

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'(rr_q) + IW'(i);
            if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
            if (!found && req_bus.req_i[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    assign accept    = (state_q == ST_BURST) && req_bus.valid_i[winner_q] && !fifo_full_i;
    assign last_word = accept && (remaining_q == LW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // WAIT keeps the winner without re-arbitrating so long bursts cannot starve.
    always_comb begin
        state_d = state_q;
        ready   = '0;
        grant   = '0;
        case (state_q)
            ST_IDLE:  if (found) state_d = room_pick ? ST_BURST : ST_WAIT;
            ST_WAIT: begin
                grant[winner_q] = 1'b1;
                if (room_q) state_d = ST_BURST;
            end
            ST_BURST: begin
                grant[winner_q] = 1'b1;
                ready[winner_q] = !fifo_full_i;
                if (last_word) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign req_bus.ready_o = ready;
    assign req_bus.grant_o = grant;
    assign busy_o          = (state_q != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            winner_q    <= '0;
            rr_q        <= '0;
            remaining_q <= '0;
            fifo_we_o   <= 1'b0;
            fifo_d_o    <= '0;
        end else begin
            fifo_we_o <= accept;
            if (accept) fifo_d_o <= req_bus.d_i[winner_q];
            if (state_q == ST_IDLE && found) begin
                winner_q    <= pick;
                remaining_q <= len_clamped[pick];
            end else if (accept) begin
                remaining_q <= remaining_q - LW'(1);
            end
            if (last_word) rr_q <= (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_burst_arbiter.sv
// Bench for fifo_wr_burst_arbiter: requester agents plus a cycle-level model of
// grant/ready/busy; written words are checked in order by a scoreboard monitor.
module tb_fifo_wr_burst_arbiter;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int SIZE = 2048;
    localparam int MB   = 64;
    localparam int MG   = 2;
    localparam int LW   = $clog2(MB) + 1;
    localparam int CW   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_full = 1'b0;
    logic [CW-1:0] fifo_count = '0;
    logic [DW-1:0] fifo_d;
    logic          fifo_we, busy;

    always #5 clk = ~clk;

    fifo_wr_burst_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .LW(LW)) bus ();

    fifo_wr_burst_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .SIZE(SIZE), .MAX_BURST(MB), .MARGIN(MG)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_bus      (bus),
        .fifo_d_o     (fifo_d),
        .fifo_we_o    (fifo_we),
        .fifo_full_i  (fifo_full),
        .fifo_count_i (fifo_count),
        .busy_o       (busy)
    );

    int checks = 0, errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] cur_words[$];
    logic [DW-1:0] mon_exp;
    int pend_len[N][$];
    // Model of what the arbiter is doing in the current cycle: 0 idle, 1 waiting, 2 bursting.
    int phase = 0, w = 0, rr = 0, rem = 0, idx = 0, vcnt = 0, vmode = 0, count_val = 0, seq = 0;
    bit rnd_count = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_len(int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    function automatic int pick_rr(logic [N-1:0] r, int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++)
            if (pend_len[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (fifo_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got write of %0h, expected no write (t=%0t)", fifo_d, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("write_data", 32'(fifo_d), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        logic [N-1:0] rq, gexp, rexp;
        bit v;
        int free;
        int l;
        @(negedge clk); #1;
        gexp = '0;
        rexp = '0;
        if (phase != 0) gexp[w] = 1'b1;
        if (phase == 2) rexp[w] = 1'b1;
        chk("grant", 32'(bus.grant_o), 32'(gexp));
        chk("ready", 32'(bus.ready_o), 32'(rexp));
        chk("busy", 32'(busy), 32'(phase != 0));

        if (rnd_count) count_val = ($urandom % 4 == 0) ? 1950 + int'($urandom % 98) : int'($urandom % 1000);
        for (int i = 0; i < N; i++) begin
            rq[i]          = (pend_len[i].size() != 0);
            bus.len_i[i]   = rq[i] ? LW'(pend_len[i][0]) : LW'($urandom);
            bus.valid_i[i] = $urandom % 2;
            bus.d_i[i]     = DW'($urandom);
        end
        bus.req_i = rq;
        case (vmode)
            0:       v = 1'b1;
            1:       v = (vcnt % 4 == 0) || (vcnt % 4 == 3);
            default: v = ($urandom % 10) < 7;
        endcase
        if (phase != 0) begin
            bus.valid_i[w] = v;
            bus.d_i[w]     = cur_words[idx];
        end
        fifo_count = CW'(count_val);

        free = SIZE - count_val - MG;
        case (phase)
            0: if (rq != 0) begin
                w = pick_rr(rq, rr);
                l = clamp_len(pend_len[w].pop_front());
                cur_words.delete();
                for (int k = 0; k < l; k++) begin
                    cur_words.push_back({4'(w), 12'(seq)});
                    exp_q.push_back({4'(w), 12'(seq)});
                    seq++;
                end
                idx   = 0;
                rem   = l;
                vcnt  = 0;
                phase = (free >= rem) ? 2 : 1;
            end
            1: if (free >= rem) phase = 2;
            default: begin
                if (v) begin
                    idx++;
                    rem--;
                    if (rem == 0) begin
                        phase = 0;
                        rr    = (w + 1) % N;
                    end
                end
                vcnt++;
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst         = 1'b1;
        bus.valid_i = '0;
        bus.req_i   = '0;
        @(negedge clk); #1;
        chk("rst_grant", 32'(bus.grant_o), 0);
        chk("rst_ready", 32'(bus.ready_o), 0);
        chk("rst_we", 32'(fifo_we), 0);
        chk("rst_data", 32'(fifo_d), 0);
        chk("rst_busy", 32'(busy), 0);
        rst   = 1'b0;
        phase = 0;
        rr    = 0;
        rem   = 0;
        idx   = 0;
        exp_q.delete();
        cur_words.delete();
    endtask

    task automatic run_all(int max_cycles);
        int n = 0;
        while ((phase != 0 || any_pending()) && n < max_cycles) begin
            step();
            n++;
        end
        if (n >= max_cycles) chk("run_timeout", 32'(n), 32'(max_cycles - 1));
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        bus.req_i   = '0;
        bus.len_i   = '0;
        bus.valid_i = '0;
        bus.d_i     = '0;
        do_reset();

        // Two bursts back to back, then rr must resume at req3.
        vmode = 0;
        pend_len[0].push_back(3);
        pend_len[2].push_back(5);
        run_all(200);
        pend_len[1].push_back(1);
        pend_len[3].push_back(1);
        run_all(100);

        // Everyone requesting: strict 0,1,2,3 rotation.
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) pend_len[i].push_back(2);
        run_all(300);

        // Not enough room: holds in WAIT, then bursts once space appears.
        pend_len[1].push_back(64);
        count_val = 2000;
        repeat (8) step();
        count_val = 1982;
        run_all(300);
        count_val = 0;

        // Length clamping; second len_i is visible during the first burst and must be ignored.
        pend_len[3].push_back(0);
        pend_len[3].push_back(100);
        run_all(300);

        // Reset mid-burst after two words, then req0 must win.
        do_reset();
        pend_len[2].push_back(8);
        n = 0;
        while (!(phase == 2 && idx >= 2) && n < 50) begin
            step();
            n++;
        end
        chk("mid_burst_reached", 32'(n < 50), 1);
        do_reset();
        pend_len[0].push_back(2);
        pend_len[3].push_back(2);
        run_all(100);

        // Valid gaps 1,0,0,1 on the winner with req dropped after grant.
        vmode = 1;
        pend_len[1].push_back(6);
        run_all(100);

        // Random traffic, random lengths and fluctuating FIFO occupancy.
        vmode     = 2;
        rnd_count = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) pend_len[$urandom % N].push_back(int'($urandom_range(0, 100)));
            run_all(6000);
        end
        rnd_count = 1'b0;
        count_val = 0;
        run_all(50);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
